// File: rtl/vga_rx_if.sv
// Parallel video bus: active-low HS/VS sync pulses, BLANK high on active pixels, 24-bit RGB.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_rx.sv
// VGA receiver: lock tracking, pixel coordinates and geometry error flags, 2-cycle input-to-output latency.
// Defining VGA_RX_CRC_EN adds a per-frame CRC-16-CCITT over the R,G,B bytes of valid pixels.
module vga_rx #(
  parameter int HDISP = 800,
  parameter int VDISP = 480
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst,
  video_if.slave                   video_ifs,
  input  logic                     err_clr,
  output logic                     pix_valid,
  output logic [$clog2(HDISP)-1:0] pix_x,
  output logic [$clog2(VDISP)-1:0] pix_y,
  output logic [23:0]              pix_rgb,
  output logic                     sof,
  output logic                     locked,
  output logic                     err_hlen,
  output logic                     err_vlen,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              frame_crc,
  output logic                     crc_valid
);
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int CW = $clog2(HDISP + 1);
  localparam int LW = $clog2(VDISP + 1);
  localparam logic [CW-1:0] HMAX = CW'(HDISP);
  localparam logic [LW-1:0] VMAX = LW'(VDISP);

  typedef enum logic [1:0] {UNLOCKED, SYNC, LOCKED} state_t;
  state_t st_q, st_d;

  // HS is not needed: line boundaries come from BLANK falling edges.
  logic          vs_q, vs_qq, blank_q, blank_qq;
  logic [23:0]   rgb_q;
  logic [CW-1:0] col_q, col_d;
  logic          col_ovf_q, col_ovf_d;
  logic [LW-1:0] line_q, line_d, line_e;
  logic          line_ovf_q, line_ovf_d, line_ovf_e;
  logic          hbad_q, hbad_d;
  logic          frame_start, line_end, active, hlen_err, vlen_bad, vlen_err, valid_d;
  logic          err_hlen_d, err_vlen_d;
  logic [15:0]   frame_cnt_d;

  logic          pix_valid_q, sof_q, locked_q, err_hlen_q, err_vlen_q;
  logic [XW-1:0] pix_x_q;
  logic [YW-1:0] pix_y_q;
  logic [23:0]   pix_rgb_q;
  logic [15:0]   frame_cnt_q;

  always_comb begin
    frame_start = vs_qq & ~vs_q;
    line_end    = blank_qq & ~blank_q;
    active      = (st_q != UNLOCKED);

    col_d     = col_q;
    col_ovf_d = col_ovf_q;
    if (line_end) begin
      col_d     = '0;
      col_ovf_d = 1'b0;
    end else if (blank_q) begin
      if (col_q == HMAX) col_ovf_d = 1'b1;
      else               col_d     = col_q + CW'(1);
    end
    hlen_err = line_end && active && ((col_q != HMAX) || col_ovf_q);

    // A line ending together with VS counts toward the frame that is closing.
    line_e     = line_q;
    line_ovf_e = line_ovf_q;
    if (line_end) begin
      if (line_q == VMAX) line_ovf_e = 1'b1;
      else                line_e     = line_q + LW'(1);
    end
    vlen_bad   = (line_e != VMAX) || line_ovf_e;
    vlen_err   = frame_start && active && vlen_bad;
    line_d     = frame_start ? '0 : line_e;
    line_ovf_d = frame_start ? 1'b0 : line_ovf_e;
    hbad_d     = frame_start ? 1'b0 : (hbad_q | hlen_err);

    st_d = st_q;
    unique case (st_q)
      UNLOCKED: if (frame_start) st_d = SYNC;
      SYNC:     if (frame_start && !vlen_bad && !hbad_q && !hlen_err) st_d = LOCKED;
      LOCKED:   if (hlen_err || vlen_err) st_d = SYNC;
      default:  st_d = UNLOCKED;
    endcase

    valid_d     = active && blank_q && (col_q < HMAX) && (line_q < VMAX);
    err_hlen_d  = hlen_err | (err_hlen_q & ~err_clr);
    err_vlen_d  = vlen_err | (err_vlen_q & ~err_clr);
    frame_cnt_d = (frame_start && st_q == LOCKED) ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      vs_q        <= 1'b1;
      vs_qq       <= 1'b1;
      blank_q     <= 1'b0;
      blank_qq    <= 1'b0;
      rgb_q       <= '0;
      st_q        <= UNLOCKED;
      col_q       <= '0;
      col_ovf_q   <= 1'b0;
      line_q      <= '0;
      line_ovf_q  <= 1'b0;
      hbad_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_rgb_q   <= '0;
      sof_q       <= 1'b0;
      locked_q    <= 1'b0;
      err_hlen_q  <= 1'b0;
      err_vlen_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vs_q        <= video_ifs.VS;
      vs_qq       <= vs_q;
      blank_q     <= video_ifs.BLANK;
      blank_qq    <= blank_q;
      rgb_q       <= video_ifs.RGB;
      st_q        <= st_d;
      col_q       <= col_d;
      col_ovf_q   <= col_ovf_d;
      line_q      <= line_d;
      line_ovf_q  <= line_ovf_d;
      hbad_q      <= hbad_d;
      pix_valid_q <= valid_d;
      if (valid_d) begin
        pix_x_q <= col_q[XW-1:0];
        pix_y_q <= line_q[YW-1:0];
      end
      pix_rgb_q   <= rgb_q;
      sof_q       <= valid_d && (col_q == '0) && (line_q == '0);
      locked_q    <= (st_d == LOCKED);
      err_hlen_q  <= err_hlen_d;
      err_vlen_q  <= err_vlen_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_rgb   = pix_rgb_q;
  assign sof       = sof_q;
  assign locked    = locked_q;
  assign err_hlen  = err_hlen_q;
  assign err_vlen  = err_vlen_q;
  assign frame_cnt = frame_cnt_q;

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_run_q, crc_next, frame_crc_q;
  logic        crc_valid_q;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always_comb begin
    crc_next = crc_run_q;
    if (pix_valid_q)
      crc_next = crc_byte(crc_byte(crc_byte(crc_run_q, pix_rgb_q[23:16]), pix_rgb_q[15:8]), pix_rgb_q[7:0]);
  end

  // The pixel still leaving the output stage at frame start belongs to the closing frame.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      crc_run_q   <= 16'hFFFF;
      frame_crc_q <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_valid_q <= frame_start && active;
      if (frame_start) begin
        crc_run_q <= 16'hFFFF;
        if (active) frame_crc_q <= crc_next;
      end else begin
        crc_run_q <= crc_next;
      end
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`else
  assign frame_crc = '0;
  assign crc_valid = 1'b0;
`endif
endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx with a reduced 8x4 geometry; checks lock, counts, error flags, reset and CRC.
`timescale 1ns/1ps
module tb_vga_rx;
  localparam int HD = 8;
  localparam int VD = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  err_clr;
  logic                  pix_valid, sof, locked, err_hlen, err_vlen, crc_valid;
  logic [$clog2(HD)-1:0] pix_x;
  logic [$clog2(VD)-1:0] pix_y;
  logic [23:0]           pix_rgb;
  logic [15:0]           frame_cnt, frame_crc;

  int n_assert = 0, n_fail = 0;
  int pv_cnt = 0, sof_cnt = 0, crcv_cnt = 0, bad_cnt = 0;
  int p0, s0, c0;
  logic [15:0] last_crc = '0;
  bit zero_mode = 1'b0;

  always #5 clk = ~clk;

  video_if vif ();
  assign vif.CLK = clk;

  vga_rx #(.HDISP(HD), .VDISP(VD)) dut (
    .pixel_clk(clk), .pixel_rst(rst), .video_ifs(vif), .err_clr(err_clr),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .sof(sof), .locked(locked), .err_hlen(err_hlen), .err_vlen(err_vlen),
    .frame_cnt(frame_cnt), .frame_crc(frame_crc), .crc_valid(crc_valid)
  );

  // Driven RGB encodes {A5, line, column}, so each valid pixel must echo its own coordinates.
  always @(negedge clk) begin
    if (pix_valid) begin
      pv_cnt++;
      if (!zero_mode && pix_rgb !== {8'hA5, 8'(pix_y), 8'(pix_x)}) bad_cnt++;
    end
    if (sof) sof_cnt++;
    if (crc_valid) begin
      crcv_cnt++;
      last_crc = frame_crc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic vs_fall;
    vif.VS = 1'b0;
    vif.BLANK = 1'b0;
    cyc; cyc;
    vif.VS = 1'b1;
    repeat (3) cyc;
  endtask

  task automatic pixel(input int ln, input int c);
    vif.BLANK = 1'b1;
    vif.RGB = zero_mode ? 24'h0 : {8'hA5, 8'(ln), 8'(c)};
    cyc;
  endtask

  task automatic line(input int npix, input int ln, input int post, input bit clr);
    vif.BLANK = 1'b0;
    vif.HS = 1'b0;
    cyc;
    vif.HS = 1'b1;
    cyc; cyc;
    for (int c = 0; c < npix; c++) pixel(ln, c);
    vif.BLANK = 1'b0;
    if (post > 0) begin
      cyc;
      err_clr = clr;
      cyc;
      err_clr = 1'b0;
    end
  endtask

  task automatic body(input int nlines, input int long_idx, input bit clr, input bit tight);
    for (int l = 0; l < nlines; l++)
      line((l == long_idx) ? HD + 1 : HD, l, (tight && l == nlines - 1) ? 0 : 2, clr && (l == long_idx));
  endtask

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] crc_zero_bytes(input int nbytes);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < nbytes * 8; i++) begin
      fb = c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
`endif

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    vif.VS = 1'b1; vif.HS = 1'b1; vif.BLANK = 1'b0; vif.RGB = '0;
    repeat (3) cyc;
    chk("rst_valid", pix_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_errh", err_hlen, 0);
    chk("rst_errv", err_vlen, 0);
    chk("rst_crc", frame_crc, 0);
    rst = 1'b0;
    cyc;

    p0 = pv_cnt;
    body(VD, -1, 0, 0);
    chk("unlocked_no_pixels", pv_cnt - p0, 0);

    vs_fall;
    chk("f1_locked", locked, 0);
    p0 = pv_cnt; s0 = sof_cnt;
    body(VD, -1, 0, 0);
    chk("f1_pixels", pv_cnt - p0, HD * VD);
    chk("f1_sof", sof_cnt - s0, 1);

    vs_fall;
    chk("f2_locked", locked, 1);
    chk("f2_errv", err_vlen, 0);
    chk("f2_fcnt", frame_cnt, 0);
    body(VD, -1, 0, 0);

    vs_fall;
    chk("f3_fcnt", frame_cnt, 1);
    p0 = pv_cnt; s0 = sof_cnt;
    body(VD, 1, 0, 0);
    chk("long_pixels", pv_cnt - p0, HD * VD);
    chk("long_sof", sof_cnt - s0, 1);
    chk("long_errh", err_hlen, 1);
    chk("long_unlock", locked, 0);

    vs_fall;
    chk("f4_locked", locked, 0);
    body(VD, -1, 0, 0);

    vs_fall;
    chk("f5_relock", locked, 1);
    chk("f5_errh_sticky", err_hlen, 1);
    chk("f5_fcnt", frame_cnt, 1);
    err_clr = 1'b1;
    cyc;
    err_clr = 1'b0;
    chk("clr_errh", err_hlen, 0);
    body(VD, -1, 0, 0);

    vs_fall;
    chk("f6_fcnt", frame_cnt, 2);
    body(VD - 1, -1, 0, 0);

    vs_fall;
    chk("short_errv", err_vlen, 1);
    chk("short_unlock", locked, 0);
    chk("short_fcnt", frame_cnt, 3);
    body(VD, -1, 0, 0);

    vs_fall;
    chk("f8_relock", locked, 1);
    chk("f8_fcnt", frame_cnt, 3);
    chk("f8_errv_sticky", err_vlen, 1);
    body(VD, 2, 1, 0);
    chk("clr_vs_new_err", err_hlen, 1);
    chk("f8_unlock", locked, 0);
    err_clr = 1'b1;
    cyc;
    err_clr = 1'b0;
    chk("clr_both_h", err_hlen, 0);
    chk("clr_both_v", err_vlen, 0);

    vs_fall;
    chk("f9_locked", locked, 0);
    body(VD, -1, 0, 1);

    vs_fall;
    chk("coinc_locked", locked, 1);
    chk("coinc_errv", err_vlen, 0);
    chk("coinc_errh", err_hlen, 0);
    body(VD, -1, 0, 0);

    vs_fall;
    chk("f11_fcnt", frame_cnt, 4);
    line(HD, 0, 2, 0);
    line(HD, 1, 2, 0);
    vif.BLANK = 1'b0;
    repeat (3) cyc;
    for (int c = 0; c < 3; c++) pixel(2, c);
    rst = 1'b1;
    pixel(2, 3);
    rst = 1'b0;
    chk("midrst_valid", pix_valid, 0);
    chk("midrst_rgb", pix_rgb, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_fcnt", frame_cnt, 0);
    for (int c = 4; c < HD; c++) pixel(2, c);
    vif.BLANK = 1'b0;
    cyc; cyc;
    line(HD, 3, 2, 0);
    chk("midrst_no_pixels", pix_valid, 0);

    vs_fall;
    chk("rst_f1_locked", locked, 0);
    chk("rst_f1_errh", err_hlen, 0);
    chk("rst_f1_errv", err_vlen, 0);
    body(VD, -1, 0, 0);
    vs_fall;
    chk("rst_f2_locked", locked, 1);

    zero_mode = 1'b1;
    body(VD, -1, 0, 0);
    c0 = crcv_cnt;
    vs_fall;
    zero_mode = 1'b0;
`ifdef VGA_RX_CRC_EN
    chk("crc_pulse", crcv_cnt - c0, 1);
    chk("crc_zero_frame", last_crc, crc_zero_bytes(HD * VD * 3));
`else
    chk("crc_pulse_absent", crcv_cnt, 0);
    chk("crc_tied_zero", frame_crc, 0);
`endif
    chk("pixel_coords", bad_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
